// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: drives an external 1-bit full adder LSB first,
// one bit per clock, with a start/busy/done handshake and registered result.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_s,
  input  logic             fa_d,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    count;
  logic             last_bit;

  assign res_next = {fa_s, res_sr[WIDTH-1:1]};
  assign last_bit = (count == CW'(WIDTH - 1));

  always_comb begin
    state_n = state;
    fa_a    = 1'b0;
    fa_b    = 1'b0;
    fa_c    = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_n = ADD;
      end
      ADD: begin
        fa_a = a_sr[0];
        fa_b = b_sr[0];
        fa_c = carry;
        if (last_bit) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            carry <= cin;
            count <= '0;
          end
        end
        ADD: begin
          res_sr <= res_next;
          carry  <= fa_d;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          count  <= count + 1'b1;
          // result is committed on the final bit edge, including that bit
          if (last_bit) begin
            sum  <= res_next;
            cout <= fa_d;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
